// File: rtl/simple_ahb_pkg.sv
// Shared types and bus-width constants for the simple_ahb bus and its slaves.
package simple_ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_t;

  // Kind of data phase currently in progress on a slave.
  typedef enum logic [1:0] {
    DP_IDLE  = 2'b00,
    DP_READ  = 2'b01,
    DP_WRITE = 2'b10,
    DP_ERROR = 2'b11
  } dphase_t;

endpackage

// File: rtl/simple_ahb_if.sv
// simple_ahb bus signal bundle; no HREADY, every data phase completes in one cycle.
interface simple_ahb_if;
  import simple_ahb_pkg::*;

  logic [ADDR_W-1:0] haddr;
  htrans_t           htrans;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  hresp_t            hresp;

  modport master_ports (
    output haddr, htrans, hwrite, hwdata,
    input  hrdata, hresp
  );

  modport slave_ports (
    input  haddr, htrans, hwrite, hwdata,
    output hrdata, hresp
  );
endinterface

// File: rtl/simple_ahb_ram.sv
// Word array with one synchronous write and one synchronous (registered) read.
module simple_ahb_ram
  import simple_ahb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned IDX_W     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/simple_ahb_slave_mem.sv
// Zero-wait-state word memory slave: address/data pipeline, decode, write forwarding.
module simple_ahb_slave_mem
  import simple_ahb_pkg::*;
#(
  parameter int unsigned       MEM_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             hclk,
  input  logic             hresetN,
  simple_ahb_if.slave_ports bus
);

  localparam int unsigned       IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(MEM_WORDS * 4);

  dphase_t           dp_q, dp_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q;
  logic [ADDR_W-1:0] offset;
  logic              addr_err;
  logic [DATA_W-1:0] ram_rdata;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the span check too.
  always_comb begin
    offset   = bus.haddr - BASE_ADDR;
    addr_err = (bus.haddr[1:0] != 2'b00) || (offset >= SPAN);
    idx_d    = offset[IDX_W+1:2];
    dp_d     = DP_IDLE;
    if (bus.htrans == NONSEQ || bus.htrans == SEQ) begin
      if (addr_err)        dp_d = DP_ERROR;
      else if (bus.hwrite) dp_d = DP_WRITE;
      else                 dp_d = DP_READ;
    end
    fwd_d = (dp_d == DP_READ) && (dp_q == DP_WRITE) && (idx_q == idx_d);
  end

  always_ff @(posedge hclk or negedge hresetN) begin
    if (!hresetN) begin
      dp_q       <= DP_IDLE;
      idx_q      <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      dp_q  <= dp_d;
      idx_q <= idx_d;
      fwd_q <= fwd_d;
      if (fwd_d) fwd_data_q <= bus.hwdata;
    end
  end

  // Write enable comes straight from the async-cleared phase flop, so reset drops a pending write.
  simple_ahb_ram #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk   (hclk),
    .we    (dp_q == DP_WRITE),
    .widx  (idx_q),
    .wdata (bus.hwdata),
    .re    (dp_d == DP_READ),
    .ridx  (idx_d),
    .rdata (ram_rdata)
  );

  always_comb begin
    bus.hrdata = '0;
    bus.hresp  = OKAY;
    case (dp_q)
      DP_READ:  bus.hrdata = fwd_q ? fwd_data_q : ram_rdata;
      DP_ERROR: bus.hresp  = ERROR;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_simple_ahb_slave_mem.sv
// Randomized + directed bench for simple_ahb_slave_mem against a word-array reference model.
module tb_simple_ahb_slave_mem;
  import simple_ahb_pkg::*;

  localparam int unsigned WORDS = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic hclk = 1'b0;
  logic hresetN = 1'b1;
  always #5 hclk = ~hclk;

  simple_ahb_if bus();

  simple_ahb_slave_mem #(
    .MEM_WORDS (WORDS),
    .BASE_ADDR (BASE)
  ) dut (
    .hclk    (hclk),
    .hresetN (hresetN),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] model_mem [WORDS];
  bit          model_known [WORDS];
  bit          pend_wr = 1'b0;
  int          pend_idx = 0;
  logic [31:0] exp_rd = '0;
  logic [1:0]  exp_resp = 2'b00;
  bit          exp_chk_rd = 1'b1;
  logic [31:0] next_wdata = '0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge hresetN) begin
    pend_wr    = 1'b0;
    exp_rd     = '0;
    exp_resp   = 2'b00;
    exp_chk_rd = 1'b1;
  end

  // Model: on each edge, commit the write whose data phase ends, then predict the new data phase.
  always @(posedge hclk) begin
    if (hresetN) begin
      logic [31:0] a;
      bit active, err;
      int idx;
      if (pend_wr) begin
        model_mem[pend_idx]   = bus.hwdata;
        model_known[pend_idx] = 1'b1;
      end
      a      = bus.haddr;
      active = (bus.htrans == NONSEQ) || (bus.htrans == SEQ);
      err    = (a % 4 != 0) || (a < BASE) || (a - BASE >= 4 * WORDS);
      idx    = int'((a - BASE) / 4) % WORDS;
      pend_wr  = active && !err && bus.hwrite;
      pend_idx = idx;
      exp_resp = (active && err) ? 2'b01 : 2'b00;
      if (!active || err) begin
        exp_rd = '0;
        exp_chk_rd = 1'b1;
      end else if (bus.hwrite) begin
        exp_chk_rd = 1'b0;
      end else begin
        exp_rd = model_mem[idx];
        exp_chk_rd = model_known[idx];
      end
    end
  end

  always @(negedge hclk) begin
    if (!hresetN) begin
      check32("reset_hrdata", bus.hrdata, 32'h0);
      check32("reset_hresp", 32'(bus.hresp), 32'h0);
    end else begin
      if (exp_chk_rd) check32("model_hrdata", bus.hrdata, exp_rd);
      check32("model_hresp", 32'(bus.hresp), 32'(exp_resp));
    end
  end

  task automatic xfer(input htrans_t t, input logic [31:0] a, input logic w, input logic [31:0] d);
    @(negedge hclk);
    bus.hwdata = next_wdata;
    bus.htrans = t;
    bus.haddr  = a;
    bus.hwrite = w;
    next_wdata = d;
  endtask

  task automatic expect_dp(input string name, input logic [31:0] rd, input hresp_t rs);
    check32({name, "_hrdata"}, bus.hrdata, rd);
    check32({name, "_hresp"}, 32'(bus.hresp), 32'(rs));
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)      return BASE + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    else if (r == 7) return BASE + 32'($urandom_range(0, 1023)) | 32'd1;
    else if (r == 8) return BASE + 32'h400 + 32'($urandom_range(0, 4095));
    else             return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < int'(WORDS); i++) model_known[i] = 1'b0;
    bus.htrans = NONSEQ;
    bus.haddr  = 32'h40;
    bus.hwrite = 1'b1;
    bus.hwdata = 32'hFFFF_FFFF;
    #1 hresetN = 1'b0;
    repeat (3) @(negedge hclk);
    bus.htrans = IDLE;
    hresetN = 1'b1;

    // Fill the whole array so every later read has a defined expectation.
    for (int i = 0; i < int'(WORDS); i++)
      xfer((i % 2 == 0) ? NONSEQ : SEQ, BASE + 32'(i * 4), 1'b1, $urandom);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);

    // Reset held 3 cycles with a NONSEQ write pending on the bus: no write lands.
    xfer(NONSEQ, 32'h40, 1'b1, 32'hA5A5_0001);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    @(negedge hclk);
    bus.htrans = NONSEQ; bus.haddr = 32'h40; bus.hwrite = 1'b1; bus.hwdata = 32'hFFFF_FFFF;
    hresetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      expect_dp("rst_hold", 32'h0, OKAY);
    end
    bus.htrans = IDLE;
    hresetN = 1'b1;
    xfer(NONSEQ, 32'h40, 1'b0, 32'h0);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    expect_dp("rst_no_write", 32'hA5A5_0001, OKAY);

    // Write, idle, read.
    xfer(NONSEQ, 32'h10, 1'b1, 32'hDEAD_BEEF);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    xfer(NONSEQ, 32'h10, 1'b0, 32'h0);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    expect_dp("wr_rd", 32'hDEAD_BEEF, OKAY);

    // Back-to-back write then read of the same word.
    xfer(NONSEQ, 32'h20, 1'b1, 32'h1234_5678);
    xfer(NONSEQ, 32'h20, 1'b0, 32'h0);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    expect_dp("fwd", 32'h1234_5678, OKAY);

    // Misaligned write.
    xfer(NONSEQ, 32'h13, 1'b1, 32'h5555_AAAA);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    expect_dp("misalign", 32'h0, ERROR);
    xfer(NONSEQ, 32'h10, 1'b0, 32'h0);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    expect_dp("misalign_keep", 32'hDEAD_BEEF, OKAY);

    // Range boundary.
    xfer(NONSEQ, 32'h3FC, 1'b1, 32'h0BAD_F00D);
    xfer(NONSEQ, 32'h400, 1'b0, 32'h0);
    xfer(NONSEQ, 32'h3FC, 1'b0, 32'h0);
    expect_dp("oob", 32'h0, ERROR);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    expect_dp("last_word", 32'h0BAD_F00D, OKAY);

    // BUSY with hwrite set is ignored.
    xfer(BUSY, 32'h10, 1'b1, 32'h1111_1111);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    expect_dp("busy", 32'h0, OKAY);
    xfer(NONSEQ, 32'h10, 1'b0, 32'h0);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    expect_dp("busy_keep", 32'hDEAD_BEEF, OKAY);

    // Reset during a write data phase discards the write.
    xfer(NONSEQ, 32'h50, 1'b1, 32'hC5C5_C5C5);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    xfer(NONSEQ, 32'h50, 1'b1, 32'h7777_7777);
    @(negedge hclk);
    bus.hwdata = next_wdata;
    bus.htrans = IDLE;
    hresetN = 1'b0;
    repeat (2) @(negedge hclk);
    hresetN = 1'b1;
    xfer(NONSEQ, 32'h50, 1'b0, 32'h0);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    expect_dp("rst_mid_write", 32'hC5C5_C5C5, OKAY);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      htrans_t t;
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) t = htrans_t'($urandom_range(0, 3));
      else                           t = ($urandom_range(0, 1) == 0) ? NONSEQ : SEQ;
      // Bias toward reusing recent addresses so forwarding gets exercised.
      a = ($urandom_range(0, 3) == 0) ? bus.haddr : rand_addr();
      xfer(t, a, 1'($urandom_range(0, 1)), $urandom);
    end
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    xfer(IDLE, 32'h0, 1'b0, 32'h0);
    @(negedge hclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
